bawsss_dmem_io: RTL and testbench

- Data-side stage directly downstream of the 16-bit single-cycle CPU.
- Consumes the CPU's memory-write strobe, address and store data; returns load data in the same cycle.
- Contains the word-addressed data RAM and a small memory-mapped I/O block: GPIO plus a prescaled 16-bit timer with compare match and interrupt.

---
 rtl/bawsss_dmem_io.sv | 78 +++++++
 tb/tb_bawsss_dmem_io.sv | 132 +++++++++++++
 2 files changed

// File: rtl/bawsss_dmem_io.sv
// bawsss_dmem_io: word-addressed data RAM plus GPIO/prescaled-timer I/O window at IO_BASE.
// Define BAWSSS_DMEM_BOUNDS_EN to trap (not alias) RAM accesses beyond RAM_WORDS.
module bawsss_dmem_io #(
  parameter int          RAM_WORDS = 256,
  parameter logic [15:0] IO_BASE   = 16'hFF00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memWrite,
  input  logic [15:0] addr,
  input  logic [15:0] writeData,
  input  logic [15:0] gpioIn,
  output logic [15:0] readData,
  output logic [15:0] gpioOut,
  output logic        timerIrq
);
  localparam int AW = $clog2(RAM_WORDS);
  logic [15:0] r_ram [RAM_WORDS];
  logic [15:0] r_gpio_out, r_sync1, r_sync2, r_prescale, r_psc, r_count, r_cmp;
  logic [2:0]  r_ctrl;
  logic        r_match;
  logic        w_io, w_oob, w_tick, w_hit, w_bounds;
  logic [15:0] w_off, w_io_rd;
  logic [6:0]  w_wr;
  assign w_io = addr >= IO_BASE;
  assign w_off = addr - IO_BASE;
`ifdef BAWSSS_DMEM_BOUNDS_EN
  logic r_bounds;
  assign w_oob = !w_io && ((addr >> AW) != '0);
  assign w_bounds = r_bounds;
  always_ff @(posedge clk)
    if (!rst) r_bounds <= 1'b0;
    else r_bounds <= w_oob || (r_bounds && !(w_wr[6] && writeData[1]));
`else
  assign w_oob = 1'b0;
  assign w_bounds = 1'b0;
`endif
  always_comb
    for (int k = 0; k < 7; k++) w_wr[k] = memWrite && w_io && (w_off == 16'(k));
  // a prescale write restarts the prescaler, so it also swallows this cycle's tick
  assign w_tick = r_ctrl[0] && (r_psc == r_prescale) && !w_wr[3];
  assign w_hit = w_tick && (r_count == r_cmp);
  assign w_io_rd = w_off == 16'd0 ? r_gpio_out :
                   w_off == 16'd1 ? r_sync2 :
                   w_off == 16'd2 ? {13'b0, r_ctrl} :
                   w_off == 16'd3 ? r_prescale :
                   w_off == 16'd4 ? r_count :
                   w_off == 16'd5 ? r_cmp :
                   w_off == 16'd6 ? {14'b0, w_bounds, r_match} : '0;
  assign readData = w_io ? w_io_rd : w_oob ? 16'hDEAD : r_ram[addr[AW-1:0]];
  assign gpioOut = r_gpio_out;
  assign timerIrq = r_match && r_ctrl[2];
  always_ff @(posedge clk)
    if (memWrite && !w_io && !w_oob) r_ram[addr[AW-1:0]] <= writeData;
  always_ff @(posedge clk)
    if (!rst) begin
      r_gpio_out <= '0;
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_ctrl     <= '0;
      r_prescale <= '0;
      r_psc      <= '0;
      r_count    <= '0;
      r_cmp      <= '0;
      r_match    <= 1'b0;
    end else begin
      r_sync1 <= gpioIn;
      r_sync2 <= r_sync1;
      if (w_wr[0]) r_gpio_out <= writeData;
      if (w_wr[2]) r_ctrl <= writeData[2:0];
      if (w_wr[3]) r_prescale <= writeData;
      if (w_wr[5]) r_cmp <= writeData;
      r_psc <= w_wr[3] ? '0 : !r_ctrl[0] ? r_psc : w_tick ? '0 : r_psc + 16'd1;
      r_count <= w_wr[4] ? writeData : !w_tick ? r_count :
                 (w_hit && r_ctrl[1]) ? '0 : r_count + 16'd1;
      r_match <= w_hit || (r_match && !(w_wr[6] && writeData[0]));
    end
endmodule

// File: tb/tb_bawsss_dmem_io.sv
// tb_bawsss_dmem_io: directed checks of RAM, GPIO, timer, priorities and reset for bawsss_dmem_io.
module tb_bawsss_dmem_io;
  localparam logic [15:0] IO = 16'hFF00;
`ifdef BAWSSS_DMEM_BOUNDS_EN
  localparam logic [15:0] RAM5 = 16'h1234;
`else
  localparam logic [15:0] RAM5 = 16'hABCD;
`endif
  logic        clk = 1'b0, rst = 1'b0, memWrite = 1'b0, timerIrq;
  logic [15:0] addr = '0, writeData = '0, gpioIn = '0, readData, gpioOut;
  int checks = 0, failures = 0;
  bawsss_dmem_io dut (
    .clk(clk), .rst(rst), .memWrite(memWrite), .addr(addr), .writeData(writeData),
    .gpioIn(gpioIn), .readData(readData), .gpioOut(gpioOut), .timerIrq(timerIrq)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    memWrite = 1'b1;
    addr = a;
    writeData = d;
    @(negedge clk);
    memWrite = 1'b0;
  endtask
  task automatic rdchk(input string tag, input logic [15:0] a, input logic [15:0] exp);
    memWrite = 1'b0;
    addr = a;
    #1;
    chk(tag, readData, exp);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b1;
    chk("rst_gpio_out", gpioOut, 16'h0);
    chk("rst_irq", 16'(timerIrq), 16'h0);
    rdchk("rst_ctrl", IO + 16'd2, 16'h0);
    rdchk("rst_status", IO + 16'd6, 16'h0);
    rdchk("rst_count", IO + 16'd4, 16'h0);
    wr(16'd5, 16'h1234);
    wr(16'd261, 16'hABCD);
    rdchk("ram_alias", 16'd5, RAM5);
`ifdef BAWSSS_DMEM_BOUNDS_EN
    rdchk("ram_oob_rd", 16'd261, 16'hDEAD);
    @(negedge clk);
    rdchk("bounds_set", IO + 16'd6, 16'h0002);
    wr(IO + 16'd6, 16'h0002);
    rdchk("bounds_clr", IO + 16'd6, 16'h0000);
`endif
    wr(IO, 16'h00F0);
    chk("gpio_out", gpioOut, 16'h00F0);
    gpioIn = 16'h5A5A;
    rdchk("gpio_in_c0", IO + 16'd1, 16'h0000);
    @(negedge clk);
    rdchk("gpio_in_c1", IO + 16'd1, 16'h0000);
    @(negedge clk);
    rdchk("gpio_in_c2", IO + 16'd1, 16'h5A5A);
    wr(IO + 16'd3, 16'd3);
    wr(IO + 16'd5, 16'd2);
    wr(IO + 16'd4, 16'd0);
    wr(IO + 16'd2, 16'h0007);
    rdchk("ctrl_rb", IO + 16'd2, 16'h0007);
    repeat (11) @(negedge clk);
    chk("irq_before_match", 16'(timerIrq), 16'h0);
    rdchk("count_pre_match", IO + 16'd4, 16'd2);
    @(negedge clk);
    chk("irq_match", 16'(timerIrq), 16'h1);
    rdchk("count_reload", IO + 16'd4, 16'd0);
    rdchk("status_match", IO + 16'd6, 16'h0001);
    wr(IO + 16'd6, 16'h0001);
    chk("irq_cleared", 16'(timerIrq), 16'h0);
    wr(IO + 16'd2, 16'h0000);
    wr(IO + 16'd3, 16'd0);
    wr(IO + 16'd5, 16'd5);
    wr(IO + 16'd4, 16'hFFFE);
    wr(IO + 16'd2, 16'h0001);
    rdchk("wrap_start", IO + 16'd4, 16'hFFFE);
    @(negedge clk);
    rdchk("wrap_ffff", IO + 16'd4, 16'hFFFF);
    @(negedge clk);
    rdchk("wrap_0000", IO + 16'd4, 16'h0000);
    rdchk("wrap_noflag", IO + 16'd6, 16'h0000);
    repeat (5) @(negedge clk);
    rdchk("wrap_0005", IO + 16'd4, 16'h0005);
    rdchk("wrap_nomatch_yet", IO + 16'd6, 16'h0000);
    @(negedge clk);
    rdchk("wrap_0006", IO + 16'd4, 16'h0006);
    rdchk("wrap_match", IO + 16'd6, 16'h0001);
    chk("wrap_irq_off", 16'(timerIrq), 16'h0);
    wr(IO + 16'd4, 16'h0100);
    rdchk("prio_count_wr", IO + 16'd4, 16'h0100);
    @(negedge clk);
    rdchk("prio_count_inc", IO + 16'd4, 16'h0101);
    wr(IO + 16'd2, 16'h0000);
    wr(IO + 16'd6, 16'h0001);
    rdchk("prio_status_clr", IO + 16'd6, 16'h0000);
    wr(IO + 16'd4, 16'd5);
    wr(IO + 16'd2, 16'h0001);
    wr(IO + 16'd6, 16'h0001);
    rdchk("prio_match_w1c", IO + 16'd6, 16'h0001);
    rdchk("prio_match_cnt", IO + 16'd4, 16'd6);
    wr(IO + 16'd3, 16'd0);
    rdchk("prio_psc_supp", IO + 16'd4, 16'd6);
    @(negedge clk);
    rdchk("prio_psc_resume", IO + 16'd4, 16'd7);
    wr(IO + 16'd7, 16'hFFFF);
    rdchk("unmapped_rd", IO + 16'd7, 16'h0000);
    wr(IO, 16'hFFFF);
    wr(IO + 16'd2, 16'h0007);
    chk("pre_rst_irq", 16'(timerIrq), 16'h1);
    chk("pre_rst_gpio", gpioOut, 16'hFFFF);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("mid_rst_gpio", gpioOut, 16'h0000);
    chk("mid_rst_irq", 16'(timerIrq), 16'h0);
    rdchk("mid_rst_ctrl", IO + 16'd2, 16'h0000);
    rdchk("mid_rst_status", IO + 16'd6, 16'h0000);
    rdchk("mid_rst_psc", IO + 16'd3, 16'h0000);
    rdchk("mid_rst_cmp", IO + 16'd5, 16'h0000);
    repeat (3) @(negedge clk);
    rdchk("mid_rst_count_hold", IO + 16'd4, 16'h0000);
    rdchk("ram_survives_rst", 16'd5, RAM5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
